// File: rtl/seg_pkg.sv
// Shared types, constants and the leading-zero mask helper for the 7-segment scan driver.
package seg_pkg;

   localparam int unsigned MAX_DIGITS = 8;
   localparam int unsigned MAX_BITS   = 4 * MAX_DIGITS;
   localparam logic [3:0]  BLANK_CODE = 4'hF;

   typedef enum logic {
      SHOW = 1'b0,
      GAP  = 1'b1
   } state_e;

   // Bit k set when digit k is a leading zero: k>0 and digits k..n-1 are all zero.
   function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_BITS-1:0] shadow,
                                                     input int                  n);
      logic [MAX_DIGITS-1:0] mask;
      logic                  all_zero;
      mask     = '0;
      all_zero = 1'b1;
      for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
         if (k < n) begin
            all_zero      = all_zero & (shadow[5'(4 * k) +: 4] == 4'h0);
            mask[3'(k)]   = all_zero & (k > 0);
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/seg_scan_driver_scan_timer.sv
// Loadable down-counter that flags the last cycle of a SHOW or GAP interval.
module scan_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         tc_c
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_en) begin
         count_d = load_val;
      end else if (count_q > W'(1)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc_c  = (count_q == W'(1));

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with double-buffered BCD value,
// leading-zero blanking and an all-off gap between digits.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned GAP_CYC    = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    load,
   input  logic                    blank_lz,
   output logic [3:0]              digit_num,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_tick
);

   localparam int unsigned MAX_CNT = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
   localparam int unsigned TW      = $clog2(MAX_CNT + 1);
   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned DW      = 4 * NUM_DIGITS;

   localparam logic [TW-1:0]         SHOW_LEN = TW'(SCAN_DIV);
   localparam logic [TW-1:0]         GAP_LEN  = TW'(GAP_CYC);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
   localparam bit                    NO_GAP   = (GAP_CYC == 0);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DW-1:0]           pend_q, pend_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [DW-1:0]           shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic [3:0]              num_q, num_d;
   logic                    tick_q, tick_d;

   logic                    t_load;
   logic [TW-1:0]           t_val;
   logic [TW-1:0]           t_count;
   logic                    t_tc;
   logic                    enter_show;
   logic                    frame_start;

   logic [MAX_BITS-1:0]     shadow_ext;
   logic [MAX_DIGITS-1:0]   lz;
   logic [2:0]              digit_pos;
   logic [3:0]              code;

   scan_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (t_load),
      .load_val (t_val),
      .count    (t_count),
      .tc_c     (t_tc)
   );

   // Scan sequencing and double-buffer handover.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      shadow_d     = shadow_q;
      t_load       = 1'b0;
      t_val        = '0;
      enter_show   = 1'b0;
      frame_start  = 1'b0;

      case (state_q)
         SHOW: begin
            if (t_tc) begin
               if (NO_GAP) begin
                  enter_show = 1'b1;
               end else begin
                  state_d = GAP;
                  t_load  = 1'b1;
                  t_val   = GAP_LEN;
               end
            end
         end
         GAP: begin
            // A zero count in GAP only occurs straight out of reset; arm the gap then.
            if (t_tc || (NO_GAP && (t_count == '0))) begin
               enter_show = 1'b1;
            end else if (t_count == '0) begin
               t_load = 1'b1;
               t_val  = GAP_LEN;
            end
         end
         default: begin
            state_d = GAP;
         end
      endcase

      if (enter_show) begin
         state_d = SHOW;
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
         t_load  = 1'b1;
         t_val   = SHOW_LEN;
      end

      frame_start = enter_show && (idx_d == '0);

      if (frame_start && pend_valid_q) begin
         shadow_d     = pend_q;
         pend_valid_d = 1'b0;
      end

      // A load coinciding with the handover lands in pending for the following frame.
      if (load) begin
         pend_d       = bcd_in;
         pend_valid_d = 1'b1;
      end
   end

   // Output selection for the state being entered.
   always_comb begin
      shadow_ext = MAX_BITS'(shadow_d);
      lz         = lz_mask(shadow_ext, int'(NUM_DIGITS));
      digit_pos  = 3'(idx_d);
      code       = shadow_ext[{digit_pos, 2'b00} +: 4];
      sel_d      = '1;
      num_d      = BLANK_CODE;
      tick_d     = frame_start;
      if (state_d == SHOW) begin
         sel_d = ~(SEL_ONE << idx_d);
         num_d = (blank_lz && lz[digit_pos]) ? BLANK_CODE : code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= GAP;
         idx_q        <= LAST_IDX;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         shadow_q     <= '1;
         sel_q        <= '1;
         num_q        <= BLANK_CODE;
         tick_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         shadow_q     <= shadow_d;
         sel_q        <= sel_d;
         num_q        <= num_d;
         tick_q       <= tick_d;
      end
   end

   assign digit_sel  = sel_q;
   assign digit_num  = num_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4-cycle lit time, 2-cycle gap, plus a no-gap instance.
module tb_seg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] bcd_in;
   logic        load;
   logic        blank_lz;

   logic [3:0]  digit_num;
   logic [3:0]  digit_sel;
   logic        frame_tick;
   logic [3:0]  digit_num0;
   logic [3:0]  digit_sel0;
   logic        frame_tick0;

   int total;
   int bad;

   seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GAP_CYC(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bcd_in     (bcd_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .digit_num  (digit_num),
      .digit_sel  (digit_sel),
      .frame_tick (frame_tick)
   );

   seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GAP_CYC(0)) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bcd_in     (bcd_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .digit_num  (digit_num0),
      .digit_sel  (digit_sel0),
      .frame_tick (frame_tick0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      bcd_in = v;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   task automatic wait_tick(input string tag);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 64 && !seen; n++) begin
         step();
         seen = frame_tick;
      end
      if (!seen) chk(tag, 32'd0, 32'd1);
   endtask

   task automatic wait_tick0(input string tag);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 64 && !seen; n++) begin
         step();
         seen = frame_tick0;
      end
      if (!seen) chk(tag, 32'd0, 32'd1);
   endtask

   // Called on a frame_tick cycle; walks one 24-cycle frame and ends on the next tick.
   task automatic check_frame(input string tag, input logic [15:0] exp_codes);
      logic [3:0] exp_sel;
      for (int k = 0; k < 4; k++) begin
         exp_sel = ~(4'b0001 << k);
         chk({tag, "_sel"}, 32'(digit_sel), 32'(exp_sel));
         chk({tag, "_num"}, 32'(digit_num), 32'(exp_codes[4*k +: 4]));
         repeat (4) step();
         chk({tag, "_gap_sel"}, 32'(digit_sel), 32'hF);
         chk({tag, "_gap_num"}, 32'(digit_num), 32'hF);
         repeat (2) step();
      end
      chk({tag, "_period"}, 32'(frame_tick), 32'd1);
   endtask

   // No-gap instance: 16-cycle frame, some digit lit every cycle.
   task automatic check_frame0(input string tag, input logic [15:0] exp_codes);
      logic [3:0] exp_sel;
      for (int k = 0; k < 4; k++) begin
         exp_sel = ~(4'b0001 << k);
         chk({tag, "_sel"}, 32'(digit_sel0), 32'(exp_sel));
         chk({tag, "_num"}, 32'(digit_num0), 32'(exp_codes[4*k +: 4]));
         for (int c = 0; c < 4; c++) begin
            chk({tag, "_lit"}, 32'(digit_sel0 != 4'hF), 32'd1);
            step();
         end
      end
      chk({tag, "_period"}, 32'(frame_tick0), 32'd1);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      bcd_in   = '0;
      load     = 1'b0;
      blank_lz = 1'b0;

      // Reset state and start-up gap
      step();
      step();
      chk("rst_sel", 32'(digit_sel), 32'hF);
      chk("rst_num", 32'(digit_num), 32'hF);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      rst_n = 1'b1;
      step();
      chk("start_gap1_sel", 32'(digit_sel), 32'hF);
      step();
      chk("start_gap2_sel", 32'(digit_sel), 32'hF);
      chk("start_gap2_tick", 32'(frame_tick), 32'd0);
      step();
      chk("first_sel", 32'(digit_sel), 32'hE);
      chk("first_tick", 32'(frame_tick), 32'd1);
      chk("first_num", 32'(digit_num), 32'hF);
      step();
      chk("tick_pulse", 32'(frame_tick), 32'd0);

      // Plain display
      do_load(16'h1234);
      wait_tick("to_1234");
      check_frame("f1234", 16'h1234);

      // Leading-zero blanking
      blank_lz = 1'b1;
      do_load(16'h0050);
      wait_tick("to_0050");
      check_frame("lz0050", 16'hFF50);
      do_load(16'h0000);
      wait_tick("to_0000");
      check_frame("lz0000", 16'hFFF0);
      do_load(16'h1000);
      wait_tick("to_1000");
      check_frame("lz1000", 16'h1000);
      do_load(16'h0050);
      wait_tick("to_0050b");
      check_frame("lz0050b", 16'hFF50);
      blank_lz = 1'b0;
      check_frame("nolz0050", 16'h0050);

      // Mid-frame load while digit 2 is lit
      repeat (12) step();
      chk("mid_d2_sel", 32'(digit_sel), 32'hB);
      chk("mid_d2_num", 32'(digit_num), 32'h0);
      do_load(16'h9999);
      repeat (5) step();
      chk("mid_d3_sel", 32'(digit_sel), 32'h7);
      chk("mid_d3_num", 32'(digit_num), 32'h0);
      wait_tick("to_9999");
      check_frame("f9999", 16'h9999);

      // Last load in a frame wins
      do_load(16'h1111);
      repeat (5) step();
      do_load(16'h2222);
      wait_tick("to_2222");
      check_frame("f2222", 16'h2222);

      // Load on the frame_tick edge with a value already pending
      do_load(16'h1357);
      repeat (22) step();
      bcd_in = 16'h2468;
      load   = 1'b1;
      step();
      load   = 1'b0;
      chk("coinc_tick", 32'(frame_tick), 32'd1);
      check_frame("coinc_old", 16'h1357);
      check_frame("coinc_new", 16'h2468);

      // Asynchronous reset mid-SHOW
      repeat (2) step();
      chk("pre_rst_sel", 32'(digit_sel), 32'hE);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sel", 32'(digit_sel), 32'hF);
      chk("arst_num", 32'(digit_num), 32'hF);
      chk("arst_tick", 32'(frame_tick), 32'd0);
      chk("arst_sel0", 32'(digit_sel0), 32'hF);
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("rerst_tick", 32'(frame_tick), 32'd1);
      check_frame("blank1", 16'hFFFF);
      check_frame("blank2", 16'hFFFF);

      // No-gap instance
      do_load(16'h4321);
      wait_tick0("to0_4321");
      check_frame0("ng4321", 16'h4321);
      check_frame0("ng4321b", 16'h4321);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexes a packed multi-digit BCD value onto a common-anode 7-segment array. Each cycle it presents one 4-bit digit code on digit_num, which the downstream per-digit seven-segment decoder consumes. It also drives the active-low digit enables. Provides double-buffered value loading, leading-zero blanking and an anti-ghosting gap between digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 50000, clk cycles each digit is lit (>=1)
GAP_CYC, 500, clk cycles all digits are off between digits (0 = no gap)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bcd_in  input  4*NUM_DIGITS  packed digits; [3:0] = digit 0 = least significant
load  input  1  1-cycle strobe; captures bcd_in into pending buffer
blank_lz  input  1  1 = blank leading zeros (level, sampled continuously)
digit_num  output  4  code for the downstream decoder; 4'hF = blank
digit_sel  output  NUM_DIGITS  active-low digit enables, one-cold while lit
frame_tick  output  1  1-cycle pulse on entry to SHOW for digit 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: digit_sel all 1s, digit_num 4'hF, frame_tick 0, state GAP, idx NUM_DIGITS-1, timer 0, shadow all 4'hF, pending 0, pending_valid 0. Assertion mid-operation forces these values immediately, without waiting for clk.
- FSM states:
  - SHOW: digit idx is lit for exactly SCAN_DIV cycles, then goes to GAP.
  - GAP: all digits off for exactly GAP_CYC cycles, then goes to SHOW with idx+1, wrapping NUM_DIGITS-1 -> 0.
  - GAP_CYC=0: GAP is skipped; SHOW goes directly to the next SHOW.
- After reset release: GAP_CYC gap cycles, then SHOW for idx 0 with a frame_tick.
- All outputs are registered. digit_sel and digit_num change on the same edge.
- In SHOW: digit_sel[idx]=0 and all other bits are 1; digit_num = the displayed code for idx.
- In GAP: digit_sel all 1s, digit_num 4'hF.
- Frame period = NUM_DIGITS*(SCAN_DIV+GAP_CYC) cycles.
- Double buffering:
  - load=1 writes bcd_in to pending and sets pending_valid.
  - On the edge entering SHOW for idx 0, if pending_valid: shadow <= pending and pending_valid is cleared.
  - A load on that same edge: shadow takes the old pending, the new value goes to pending, and pending_valid stays 1.
  - Multiple loads within one frame: last wins.
  - Displayed data never changes mid-frame.
- Leading-zero blanking (computed from shadow when blank_lz=1):
  - Digit k is blanked (code 4'hF) if k>0 and shadow digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - blank_lz=0: shadow codes are passed unchanged.
- Non-BCD nibbles (A-F) are passed through unchanged; the downstream decoder blanks them.
- Timer width is clog2(max(SCAN_DIV,GAP_CYC)+1). It counts down to 1 and reloads on each state transition; no overflow is possible.

Decomposition:
- Package seg_pkg:
  - BLANK_CODE = 4'hF
  - state enum {SHOW, GAP}
  - function lz_mask(shadow, n) returning a per-digit blank mask
- Sub-module scan_timer: a loadable down-counter with a terminal-count pulse, used for both SHOW and GAP durations.
- Top level holds the FSM, idx counter, pending/shadow registers and the output mux.

Test Plan:
(All scenarios use NUM_DIGITS=4, SCAN_DIV=4, GAP_CYC=2.)
- Reset: during rst_n=0, digit_sel=4'b1111 and digit_num=4'hF. After release: 2 gap cycles, then digit_sel=4'b1110 with frame_tick=1 for 1 cycle. digit_num=4'hF because shadow is blank.
- Load 16'h1234, blank_lz=0: from the next frame_tick, digit_num=4,3,2,1 with digit_sel 1110, 1101, 1011, 0111. Each is lit 4 cycles, separated by 2 cycles of 1111/4'hF. Frame period = 24 cycles.
- Leading zeros, blank_lz=1:
  - Load 16'h0050 -> digits 0, 5, F, F.
  - Load 16'h0000 -> digits 0, F, F, F.
  - Load 16'h1000 -> digits 0, 0, 0, 1 (no blanking).
  - Toggling blank_lz to 0 restores the zeros on the next lit digit.
- Mid-frame and coincident loads:
  - Load 16'h9999 while digit 2 is lit: digits 2 and 3 keep the old value; 9s appear from the next frame_tick.
  - Loads 16'h1111 then 16'h2222 within one frame -> only 2s are displayed.
  - Load on the frame_tick edge -> shown one frame later.
- Reset mid-SHOW: drop rst_n between clk edges -> outputs go to 1111/4'hF immediately. After release, the display is blank until a new load.
- GAP_CYC=0 variant: consecutive digits are lit back-to-back, digit_sel is never all-1s after the first frame, and the frame period is 16 cycles.
